// File: rtl/mod_pkg.sv
// Shared definitions for the modulator sequencing path: controller states,
// symbol/DAC widths and small decode helpers.
package mod_pkg;

    localparam int unsigned IQ_W  = 4;
    localparam int unsigned DAC_W = 10;
    localparam int unsigned UCNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } mod_state_e;

    typedef struct packed {
        logic areset;
        logic ena;
        logic active;
        logic fault;
    } pll_ctl_t;

    localparam pll_ctl_t CTL_RST = '{areset: 1'b1, ena: 1'b0, active: 1'b0, fault: 1'b0};

    function automatic logic [UCNT_W-1:0] sat_inc8(input logic [UCNT_W-1:0] v);
        logic [UCNT_W-1:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // PLL control pins and status flags implied by a controller state.
    function automatic pll_ctl_t decode_ctl(input mod_state_e st);
        pll_ctl_t c;
        case (st)
            ST_IDLE:      c = '{areset: 1'b1, ena: 1'b0, active: 1'b0, fault: 1'b0};
            ST_PLL_RST:   c = '{areset: 1'b1, ena: 1'b1, active: 1'b0, fault: 1'b0};
            ST_WAIT_LOCK: c = '{areset: 1'b0, ena: 1'b1, active: 1'b0, fault: 1'b0};
            ST_RUN:       c = '{areset: 1'b0, ena: 1'b1, active: 1'b1, fault: 1'b0};
            ST_FAULT:     c = '{areset: 1'b1, ena: 1'b0, active: 1'b0, fault: 1'b1};
            default:      c = CTL_RST;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous PLL status lines.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Metastability stage followed by the resolved stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/mod_ctrl.sv
// I/Q modulator sequencing controller: PLL reset/lock bring-up, lock
// supervision and fixed-rate symbol pacing into the iqmod inputs.
module mod_ctrl
    import mod_pkg::*;
#(
    parameter int unsigned       SYM_DIV       = 16,
    parameter int unsigned       ARESET_CYCLES = 8,
    parameter int unsigned       LOCK_TIMEOUT  = 1024,
    parameter int unsigned       MAX_RETRIES   = 3,
    parameter logic [IQ_W-1:0]   IDLE_I        = 4'd15,
    parameter logic [IQ_W-1:0]   IDLE_Q        = 4'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              pll_areset,
    output logic              pll_ena,
    input  logic              pll_locked,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [IQ_W-1:0]   sym_i,
    input  logic [IQ_W-1:0]   sym_q,
    output logic [IQ_W-1:0]   i_out,
    output logic [IQ_W-1:0]   q_out,
    output logic              tx_active,
    output logic              fault,
    output logic              lock_lost,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > ARESET_CYCLES) ? LOCK_TIMEOUT : ARESET_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W   = $clog2(SYM_DIV);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] ARS_LAST = CNT_W'(ARESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);

    mod_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [RTY_W-1:0]  rty_q, rty_d;
    logic [IQ_W-1:0]   i_q, i_d;
    logic [IQ_W-1:0]   q_q, q_d;
    logic [UCNT_W-1:0] urun_q, urun_d;
    logic              lost_q, lost_d;
    pll_ctl_t          ctl_q, ctl_d;
    logic              lock_s;
    logic              tick_s;

    sync2 #(.W(1)) u_lock_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (pll_locked),
        .sync_o  (lock_s)
    );

    assign tick_s = (state_q == ST_RUN) && (div_q == DIV_LAST);
    // Lock loss and a falling enable both pre-empt the tick's handshake.
    assign sym_ready = tick_s && lock_s && enable && !reset;

    // Next-state, counter and symbol-path computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        rty_d   = rty_q;
        i_d     = i_q;
        q_d     = q_q;
        urun_d  = urun_q;
        lost_d  = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            div_d   = '0;
            rty_d   = '0;
            i_d     = IDLE_I;
            q_d     = IDLE_Q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
                ST_PLL_RST: begin
                    if (cnt_q == ARS_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        div_d   = '0;
                        rty_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_d = '0;
                        rty_d = rty_q + RTY_ONE;
                        if ((rty_q + RTY_ONE) == RTY_MAX) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_PLL_RST;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        // Retry count deliberately survives a lock drop.
                        lost_d  = 1'b1;
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                        div_d   = '0;
                        i_d     = IDLE_I;
                        q_d     = IDLE_Q;
                    end else if (tick_s) begin
                        div_d = '0;
                        if (sym_valid) begin
                            i_d = sym_i;
                            q_d = sym_q;
                        end else begin
                            i_d    = IDLE_I;
                            q_d    = IDLE_Q;
                            urun_d = sat_inc8(urun_q);
                        end
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    div_d   = '0;
                    rty_d   = '0;
                    i_d     = IDLE_I;
                    q_d     = IDLE_Q;
                end
            endcase
        end
        ctl_d = decode_ctl(state_d);
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            rty_q   <= '0;
            i_q     <= IDLE_I;
            q_q     <= IDLE_Q;
            urun_q  <= '0;
            lost_q  <= 1'b0;
            ctl_q   <= CTL_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            rty_q   <= rty_d;
            i_q     <= i_d;
            q_q     <= q_d;
            urun_q  <= urun_d;
            lost_q  <= lost_d;
            ctl_q   <= ctl_d;
        end
    end

    assign pll_areset   = ctl_q.areset;
    assign pll_ena      = ctl_q.ena;
    assign tx_active    = ctl_q.active;
    assign fault        = ctl_q.fault;
    assign lock_lost    = lost_q;
    assign i_out        = i_q;
    assign q_out        = q_q;
    assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_mod_ctrl.sv
// Self-checking bench for mod_ctrl: directed sequence plus a symbol scoreboard.
module tb_mod_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pll_areset;
    logic       pll_ena;
    logic       pll_locked;
    logic       sym_valid;
    logic       sym_ready;
    logic [3:0] sym_i;
    logic [3:0] sym_q;
    logic [3:0] i_out;
    logic [3:0] q_out;
    logic       tx_active;
    logic       fault;
    logic       lock_lost;
    logic [7:0] underrun_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_e;
    int         ur_model = 0;

    mod_ctrl #(
        .SYM_DIV       (16),
        .ARESET_CYCLES (8),
        .LOCK_TIMEOUT  (64),
        .MAX_RETRIES   (3),
        .IDLE_I        (4'd15),
        .IDLE_Q        (4'd0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pll_areset   (pll_areset),
        .pll_ena      (pll_ena),
        .pll_locked   (pll_locked),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_i        (sym_i),
        .sym_q        (sym_q),
        .i_out        (i_out),
        .q_out        (q_out),
        .tx_active    (tx_active),
        .fault        (fault),
        .lock_lost    (lock_lost),
        .underrun_cnt (underrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: each accepted tick predicts the next-cycle I/Q and underrun count.
    always @(negedge clk) begin
        if (reset) begin
            ur_model = 0;
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                chk_eq("sb_iq", {i_out, q_out}, exp_e);
                chk_eq("sb_urun", underrun_cnt, ur_model);
            end
            if (sym_ready) begin
                if (sym_valid) begin
                    exp_q.push_back({sym_i, sym_q});
                end else begin
                    exp_q.push_back({4'd15, 4'd0});
                    if (ur_model < 255) ur_model++;
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        reset      = 1'b1;
        enable     = 1'b0;
        pll_locked = 1'b0;
        sym_valid  = 1'b0;
        sym_i      = 4'd0;
        sym_q      = 4'd0;

        // Reset values
        step(3);
        chk_eq("rst_areset", pll_areset, 1);
        chk_eq("rst_ena", pll_ena, 0);
        chk_eq("rst_i", i_out, 15);
        chk_eq("rst_q", q_out, 0);
        chk_eq("rst_ready", sym_ready, 0);
        chk_eq("rst_tx", tx_active, 0);
        chk_eq("rst_fault", fault, 0);
        chk_eq("rst_lost", lock_lost, 0);
        chk_eq("rst_urun", underrun_cnt, 0);
        reset = 1'b0;
        step(1);
        chk_eq("idle_areset", pll_areset, 1);

        // Enable: areset held with ena for exactly 8 cycles
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk_eq("prst_areset", pll_areset, 1);
            chk_eq("prst_ena", pll_ena, 1);
        end
        step(1);
        chk_eq("wait_areset", pll_areset, 0);
        chk_eq("wait_ena", pll_ena, 1);

        // Lock at cycle 20 of WAIT_LOCK -> RUN 3 cycles later
        step(20);
        pll_locked = 1'b1;
        step(2);
        chk_eq("lock_lat_pre", tx_active, 0);
        step(1);
        chk_eq("lock_lat", tx_active, 1);

        // Stream valid symbols
        sym_valid = 1'b1;
        sym_i = 4'd3; sym_q = 4'd5;
        step(14);
        chk_eq("first_tick_early", sym_ready, 0);
        step(1);
        chk_eq("first_tick", sym_ready, 1);
        step(1);
        chk_eq("sym0_i", i_out, 3);
        chk_eq("sym0_q", q_out, 5);
        chk_eq("post_tick_ready", sym_ready, 0);
        sym_i = 4'd9; sym_q = 4'd1;
        step(15);
        chk_eq("second_tick", sym_ready, 1);
        step(1);
        chk_eq("sym1_i", i_out, 9);
        chk_eq("sym1_q", q_out, 1);

        // Underrun: two ticks, then saturation
        sym_valid = 1'b0;
        step(32);
        chk_eq("urun_i", i_out, 15);
        chk_eq("urun_q", q_out, 0);
        chk_eq("urun_2", underrun_cnt, 2);
        step(300 * 16);
        chk_eq("urun_sat", underrun_cnt, 255);

        // Lock loss coincident with a tick carrying a valid symbol
        sym_valid = 1'b1;
        sym_i = 4'd7; sym_q = 4'd2;
        step(16);
        chk_eq("pre_loss_i", i_out, 7);
        sym_i = 4'd12; sym_q = 4'd6;
        step(13);
        pll_locked = 1'b0;
        step(2);
        chk_eq("loss_tick_ready", sym_ready, 0);
        chk_eq("loss_tick_tx", tx_active, 1);
        step(1);
        chk_eq("lost_pulse", lock_lost, 1);
        chk_eq("lost_tx", tx_active, 0);
        chk_eq("lost_areset", pll_areset, 1);
        chk_eq("lost_i", i_out, 15);
        chk_eq("lost_q", q_out, 0);
        step(1);
        chk_eq("lost_pulse_end", lock_lost, 0);

        // Relock: fresh divider
        step(7);
        chk_eq("relock_wait", pll_areset, 0);
        pll_locked = 1'b1;
        step(3);
        chk_eq("relock_tx", tx_active, 1);
        step(14);
        chk_eq("relock_early", sym_ready, 0);
        step(1);
        chk_eq("relock_tick", sym_ready, 1);
        step(1);
        chk_eq("relock_i", i_out, 12);
        chk_eq("relock_q", q_out, 6);

        // Reset mid-RUN on a tick
        step(15);
        chk_eq("pre_rst_tick", sym_ready, 1);
        reset = 1'b1;
        pll_locked = 1'b0;
        #1;
        chk_eq("rst_tick_ready", sym_ready, 0);
        step(1);
        chk_eq("midrst_tx", tx_active, 0);
        chk_eq("midrst_areset", pll_areset, 1);
        chk_eq("midrst_ena", pll_ena, 0);
        chk_eq("midrst_i", i_out, 15);
        chk_eq("midrst_urun", underrun_cnt, 0);
        reset = 1'b0;

        // Lock timeout: three rounds then FAULT
        wait_cycles = 0;
        for (int k = 0; k < 216; k++) begin
            step(1);
            if (pll_areset == 1'b0) wait_cycles++;
        end
        chk_eq("tmo_wait_cycles", wait_cycles, 192);
        chk_eq("tmo_prefault", fault, 0);
        step(1);
        chk_eq("tmo_fault", fault, 1);
        chk_eq("tmo_ena", pll_ena, 0);
        chk_eq("tmo_areset", pll_areset, 1);
        step(5);
        chk_eq("fault_hold", fault, 1);
        enable = 1'b0;
        step(1);
        chk_eq("fault_exit", fault, 0);
        chk_eq("fault_exit_ena", pll_ena, 0);
        enable = 1'b1;
        step(1);
        chk_eq("reenable_ena", pll_ena, 1);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mod_ctrl.md
# mod_ctrl

Sequencing controller for the I/Q modulator path. Brings the synthesis PLL out of reset and waits for lock. Once locked, it paces 4-bit I/Q symbols from an upstream valid/ready source into the `iqmod` inputs at a fixed symbol rate. It inserts an idle symbol on underrun and restarts the PLL on loss of lock. It sits between the symbol source and the `iqmod`/`thepll` pair inside `modulator`, replacing the static `i`/`q`/`pllena`/`areset` registers.

## Interface
Parameters:
- `SYM_DIV`, 16: `clk` cycles per symbol (≥2).
- `ARESET_CYCLES`, 8: cycles `pll_areset` is held high per PLL restart (≥1).
- `LOCK_TIMEOUT`, 1024: cycles to wait for synchronized lock before a retry.
- `MAX_RETRIES`, 3: failed lock attempts before entering FAULT.
- `IDLE_I`, 4'd15: I value driven when no symbol is available.
- `IDLE_Q`, 4'd0: Q value driven when no symbol is available.

Ports:
- `clk` in 1: reference clock, same net that feeds the PLL `inclk`.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run request; low forces IDLE.
- `pll_areset` out 1: to PLL `areset`.
- `pll_ena` out 1: to PLL `pllena`.
- `pll_locked` in 1: PLL `locked`; asynchronous to `clk`.
- `sym_valid` in 1: upstream symbol available.
- `sym_ready` out 1: symbol accepted this cycle when `sym_valid` is also high.
- `sym_i` in 4, `sym_q` in 4: symbol payload.
- `i_out` out 4, `q_out` out 4: to `iqmod` `i`/`q`.
- `tx_active` out 1: high in RUN.
- `fault` out 1: high in FAULT.
- `lock_lost` out 1: one-cycle pulse when lock drops in RUN.
- `underrun_cnt` out 8: saturating count of idle-symbol insertions.

## Operation
- `pll_locked` passes through a 2-flop synchronizer → `lock_s`. All decisions use `lock_s`.
- States and transitions:
  - IDLE: `pll_areset`=1, `pll_ena`=0. Moves to PLL_RST when `enable`=1.
  - PLL_RST: `pll_areset`=1, `pll_ena`=1 for `ARESET_CYCLES` cycles, then WAIT_LOCK.
  - WAIT_LOCK: `pll_areset`=0, `pll_ena`=1, timeout counter running.
    - `lock_s`=1 → RUN; retry counter clears.
    - Counter reaches `LOCK_TIMEOUT`-1 → retry counter increments. Go to PLL_RST, or to FAULT if the counter reaches `MAX_RETRIES`.
  - RUN: symbol divider free-runs 0..`SYM_DIV`-1; tick when the divider = `SYM_DIV`-1.
    - `lock_s` falls → `lock_lost` pulse and → PLL_RST. The retry counter is not cleared on this path.
  - FAULT: `pll_areset`=1, `pll_ena`=0. Exit only via `reset` or `enable`=0 (→ IDLE).
- `enable`=0 in any state → IDLE next cycle. The divider, timeout counter and retry counter clear.
- Symbol pacing, RUN only:
  - `sym_ready` = RUN & tick (combinational). Never high outside RUN.
  - Tick with `sym_valid`=1 → `i_out`/`q_out` load `sym_i`/`sym_q`.
  - Tick with `sym_valid`=0 → `i_out`/`q_out` load `IDLE_I`/`IDLE_Q` and `underrun_cnt` increments, saturating at 255.
- Leaving RUN for any reason → `i_out`/`q_out` = `IDLE_I`/`IDLE_Q` next cycle.
- The first tick in RUN occurs `SYM_DIV` cycles after entry; the divider resets to 0 on entry.

## Timing
- Reset values: state IDLE, `pll_areset`=1, `pll_ena`=0, `i_out`=`IDLE_I`, `q_out`=`IDLE_Q`, `sym_ready`=0, `tx_active`=0, `fault`=0, `lock_lost`=0, `underrun_cnt`=0, all counters 0.
- `reset` has priority over `enable` and everything else. Reset mid-RUN drops the in-flight tick; no handshake completes in the reset cycle.
- Outputs from the symbol path are registered: `i_out`/`q_out` change the cycle after the tick. Symbol-to-output latency is 1 cycle.
- Lock latency: `pll_locked` rising → RUN 3 cycles later (2 synchronizer cycles + 1 state register).
- Tick coincident with lock loss: lock loss wins. No symbol is accepted and `sym_ready`=0 that cycle.
- `enable` falling on a tick: no transfer.
- One symbol per tick maximum. Back-to-back `sym_valid` is honoured every `SYM_DIV` cycles.

## Structure
- Shared package `mod_pkg`: state enum (IDLE, PLL_RST, WAIT_LOCK, RUN, FAULT), `IQ_W`=4, `DAC_W`=10.
- One sub-module `sync2` (2-flop synchronizer), reused later for other PLL status lines.
- Everything else is flat in `mod_ctrl`.

## Test plan
- **Reset, then enable:** reset → all outputs at reset values. Assert `enable` → `pll_areset` high exactly 8 cycles with `pll_ena`=1, then low.
- **Lock and stream:** `locked` rises at cycle 20 of WAIT_LOCK → `tx_active` 3 cycles later. Symbols (3,5),(9,1) always valid → `i_out`/`q_out` update every 16 cycles, 1 cycle after each `sym_ready`.
- **Underrun:** `sym_valid` low for 2 ticks → outputs (15,0) and `underrun_cnt`=2. Hold low for 300 ticks → `underrun_cnt` saturates at 255.
- **Lock timeout:** `locked` never rises, `LOCK_TIMEOUT`=64 → 3 PLL_RST/WAIT_LOCK rounds, then `fault`=1 with `pll_ena`=0. Drop `enable` → IDLE.
- **Lock loss:** drop `locked` mid-RUN → `lock_lost` pulses once, outputs return to (15,0), `pll_areset` reasserts. Relock → RUN resumes with a fresh 16-cycle divider.
- **Collisions:** lock loss on a tick with `sym_valid`=1 → no handshake. Separately, `reset` asserted mid-RUN → reset values next cycle.
